voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_sched_pkg.sv | 36 +++
 rtl/irq_edge_detect.sv | 30 +++
 rtl/voice_scheduler.sv | 178 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voice_sched_pkg
// Description : Shared constants, FSM state type and helper function for the
//               voice scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package voice_sched_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int NOTE_W    = 7;
  localparam int SLOT_W    = 3;
  // Each table entry is one byte: 7-bit note plus a don't-care top bit.
  localparam int ENTRY_W   = 8;
  localparam int TABLE_W   = NUM_SLOTS * ENTRY_W;
  localparam int CNT_W     = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SCAN  = 4'b0010,
    ST_ISSUE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  // Number of non-empty slots in a raw note table.
  function automatic logic [CNT_W-1:0] count_active(input logic [TABLE_W-1:0] tbl);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (tbl[k*ENTRY_W +: NOTE_W] != '0) n = n + CNT_W'(1);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_detect
// Description : Rising-edge detector against the registered previous level.
//               The pulse is combinational from the current level, so it is
//               high in the same cycle the level first reads high.
// Ports       : clk     - clock
//               rstn    - asynchronous active-low reset (history cleared)
//               i_level - level input
//               o_rise  - one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler
// Description : Per-frame sweep of an 8-slot active-note table. On each
//               frame_tick the table snapshot (refreshed only if the note
//               processor flagged a change) is scanned one slot per cycle and
//               every non-empty slot is issued as a valid/ready request to the
//               shared tone datapath. A request that waits READY_TIMEOUT
//               cycles without req_ready is dropped and flagged sticky.
// Ports       : clk, rstn (async active-low)
//               note_data[63:0], note_irq, frame_tick      - table side
//               req_valid/ready/slot/note/last             - datapath side
//               frame_done, busy, overrun, timeout_err     - status
//               active_count[3:0] (optional)               - snapshot count
// Options     : VOICE_SCHED_ACTIVE_COUNT_EN adds the active_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int READY_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [TABLE_W-1:0] note_data,
  input  logic               note_irq,
  input  logic               frame_tick,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [SLOT_W-1:0]  req_slot,
  output logic [NOTE_W-1:0]  req_note,
  output logic               req_last,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
`ifdef VOICE_SCHED_ACTIVE_COUNT_EN
  ,
  output logic [CNT_W-1:0]   active_count
`endif
);

  localparam int                c_wait_w    = $clog2(READY_TIMEOUT + 1);
  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(READY_TIMEOUT - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [NUM_SLOTS-1:0][NOTE_W-1:0] r_snapshot;
  logic [SLOT_W-1:0]               r_ptr;
  logic [c_wait_w-1:0]             r_wait;
  logic                            r_pending;
  logic                            r_timeout_err;

  logic                            w_irq_rise;
  logic                            w_start;
  logic                            w_adv;
  logic                            w_timeout;
  logic                            w_none_above;
  logic [NUM_SLOTS-1:0]            w_slot_nz;
  logic [NUM_SLOTS-1:0][NOTE_W-1:0] w_table_notes;
  logic [NUM_SLOTS-1:0]            w_table_msb;
  logic                            w_unused_msb;

  irq_edge_detect u_irq_edge (
    .clk     (clk),
    .rstn    (rstn),
    .i_level (note_irq),
    .o_rise  (w_irq_rise)
  );

  // Split the raw table into note fields; the top bit of each byte is
  // meaningless and only sunk here.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign w_table_notes[k] = note_data[k*ENTRY_W +: NOTE_W];
    assign w_table_msb[k]   = note_data[k*ENTRY_W + NOTE_W];
    assign w_slot_nz[k]     = |r_snapshot[k];
  end
  assign w_unused_msb = ^w_table_msb;

  // req_last: nothing non-empty above the current pointer.
  always_comb begin
    w_none_above = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if ((k > int'(r_ptr)) && w_slot_nz[k]) w_none_above = 1'b0;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_slot_nz[r_ptr])          w_state_nxt = ST_ISSUE;
        else if (r_ptr == c_last_slot) w_state_nxt = ST_DONE;
      end
      ST_ISSUE: begin
        // A handshake wins over a timeout landing in the same cycle.
        if (req_ready) begin
          w_adv = 1'b1;
        end else if (r_wait == c_wait_max) begin
          w_adv     = 1'b1;
          w_timeout = 1'b1;
        end
        if (w_adv) w_state_nxt = (r_ptr == c_last_slot) ? ST_DONE : ST_SCAN;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_snapshot    <= '0;
      r_ptr         <= '0;
      r_wait        <= '0;
      r_pending     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_ptr <= '0;
        if (r_pending) r_snapshot <= w_table_notes;
      end else if ((r_state == ST_SCAN) && !w_slot_nz[r_ptr] && (r_ptr != c_last_slot)) begin
        r_ptr <= r_ptr + SLOT_W'(1);
      end else if (w_adv && (r_ptr != c_last_slot)) begin
        r_ptr <= r_ptr + SLOT_W'(1);
      end

      // A new edge in the loading cycle keeps the flag set for next frame.
      if (w_irq_rise)   r_pending <= 1'b1;
      else if (w_start) r_pending <= 1'b0;

      // Counts stalled ISSUE cycles; zero on every ISSUE entry.
      if ((r_state == ST_ISSUE) && !w_adv) r_wait <= r_wait + c_wait_w'(1);
      else                                 r_wait <= '0;

      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

`ifdef VOICE_SCHED_ACTIVE_COUNT_EN
  logic [CNT_W-1:0] r_active_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      r_active_count <= '0;
    else if (w_start && r_pending)  r_active_count <= count_active(note_data);
  end

  assign active_count = r_active_count;
`endif

  // ------------------------------------------------------------ outputs
  assign req_valid   = (r_state == ST_ISSUE);
  assign req_slot    = req_valid ? r_ptr : '0;
  assign req_note    = req_valid ? r_snapshot[r_ptr] : '0;
  assign req_last    = req_valid & w_none_above;
  assign frame_done  = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = frame_tick & busy;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_scheduler
// Description : Self-checking bench for voice_scheduler. A frame-level model
//               derives the expected request list from the snapshot and the
//               request timeline from the sweep rules (one cycle per slot,
//               issue lasts until ready or the timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_scheduler;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] note_data = '0;
  logic        note_irq = 1'b0;
  logic        frame_tick = 1'b0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [2:0]  req_slot;
  logic [6:0]  req_note;
  logic        req_last;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
`ifdef VOICE_SCHED_ACTIVE_COUNT_EN
  logic [3:0]  active_count;
`endif

  voice_scheduler #(.READY_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .note_data   (note_data),
    .note_irq    (note_irq),
    .frame_tick  (frame_tick),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_slot    (req_slot),
    .req_note    (req_note),
    .req_last    (req_last),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
`ifdef VOICE_SCHED_ACTIVE_COUNT_EN
    ,
    .active_count(active_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  bit          m_pending = 1'b0;
  logic [6:0]  m_snap [8];
  logic [63:0] m_table = '0;
  bit          m_terr = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int k = 0; k < 8; k++) if (m_snap[k] != 0) n++;
    return n;
  endfunction

  function automatic logic [63:0] rand_table();
    logic [63:0] t;
    for (int k = 0; k < 8; k++) begin
      t[8*k+7] = 1'($urandom_range(1));
      t[8*k +: 7] = ($urandom_range(1) == 1) ? 7'($urandom_range(127, 1)) : 7'd0;
    end
    return t;
  endfunction

  task automatic check_count(input string tag);
`ifdef VOICE_SCHED_ACTIVE_COUNT_EN
    check_eq(tag, active_count, 64'(model_count()));
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      req_ready  = 1'($urandom_range(1));
      #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_valid", req_valid, 0);
      check_eq("idle_terr", timeout_err, m_terr);
      check_count("idle_count");
    end
  endtask

  task automatic load_table(input logic [63:0] t);
    @(posedge clk); #1;
    note_data = t;
    note_irq  = 1'b1;
    m_table   = t;
    m_pending = 1'b1;
    @(posedge clk); #1;
    note_irq = 1'b0;
    idle_cycles(2);
  endtask

  task automatic do_frame(input int ready_pct, input bit inject_ovr,
                          input bit irq_mid, input logic [63:0] mid_table);
    int  q[$];
    int  next_start, done_cyc, streak, s;
    bit  exp_valid, finished;
    // cycle 0: frame_tick
    @(posedge clk); #1;
    frame_tick = 1'b1;
    req_ready  = 1'b0;
    if (m_pending) begin
      for (int k = 0; k < 8; k++) m_snap[k] = m_table[8*k +: 7];
      m_pending = 1'b0;
    end
    q.delete();
    for (int k = 0; k < 8; k++) if (m_snap[k] != 0) q.push_back(k);
    // Timeline anchor: a virtual slot -1 consumed at cycle 0.
    if (q.size() > 0) begin
      next_start = 1 + (q[0] + 1);
      done_cyc   = 100000;
    end else begin
      next_start = 100000;
      done_cyc   = 9;
    end
    streak   = 0;
    finished = 1'b0;
    #1;
    check_eq("tick_busy", busy, 0);
    check_eq("tick_overrun", overrun, 0);
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(posedge clk); #1;
      frame_tick = inject_ovr && (cyc == 3);
      req_ready  = ($urandom_range(99) < ready_pct);
      if (irq_mid && cyc == 4) begin
        note_data = mid_table;
        note_irq  = 1'b1;
        m_table   = mid_table;
        m_pending = 1'b1;
      end
      if (irq_mid && cyc == 6) note_irq = 1'b0;
      #1;
      exp_valid = (q.size() > 0) && (cyc >= next_start);
      check_eq("req_valid", req_valid, exp_valid);
      if (exp_valid) begin
        check_eq("req_slot", req_slot, q[0]);
        check_eq("req_note", req_note, m_snap[q[0]]);
        check_eq("req_last", req_last, q.size() == 1);
      end else begin
        check_eq("req_idle_zero", {req_slot, req_note, req_last}, 0);
      end
      check_eq("frame_done", frame_done, (q.size() == 0) && (cyc == done_cyc));
      check_eq("busy", busy, 1);
      check_eq("overrun", overrun, frame_tick);
      check_eq("timeout_err", timeout_err, m_terr);
      check_count("active_count");
      if (exp_valid) begin
        streak++;
        if (req_ready || streak == TO) begin
          if (!req_ready) m_terr = 1'b1;
          s = q.pop_front();
          streak = 0;
          if (q.size() > 0) next_start = cyc + 1 + (q[0] - s);
          else              done_cyc   = cyc + 8 - s;
        end
      end
      if (cyc == done_cyc) finished = 1'b1;
    end
    check_eq("frame_finished", finished, 1);
    idle_cycles(1);
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_terr    = 1'b0;
    for (int k = 0; k < 8; k++) m_snap[k] = '0;
  endtask

  initial begin
    logic [63:0] t;
    bit seen;
    model_reset();
    // Reset state
    #12;
    check_eq("reset_outputs",
             {req_valid, req_slot, req_note, req_last, frame_done, busy, overrun, timeout_err}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_cycles(2);

    // Empty table after reset: done at cycle 9
    do_frame(100, 1'b0, 1'b0, '0);

    // Slot0 = 60, slot3 = 64, always ready
    t = '0; t[6:0] = 7'd60; t[30:24] = 7'd64;
    load_table(t);
    do_frame(100, 1'b0, 1'b0, '0);

    // Slot5 = 72, never ready -> timeout
    t = '0; t[46:40] = 7'd72; t[47] = 1'b1;
    load_table(t);
    do_frame(0, 1'b0, 1'b0, '0);

    // Overrun during a sweep
    do_frame(50, 1'b1, 1'b0, '0);

    // Table change mid-sweep: old snapshot now, new one next frame
    t = '0; t[14:8] = 7'd33; t[62:56] = 7'd99;
    do_frame(100, 1'b0, 1'b1, t);
    do_frame(100, 1'b0, 1'b0, '0);

    // Explicit empty table load
    load_table(64'h8080_8080_8080_8080);
    do_frame(100, 1'b0, 1'b0, '0);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      int pct;
      case ($urandom_range(3))
        0: pct = 100;
        1: pct = 60;
        2: pct = 20;
        default: pct = 0;
      endcase
      if ($urandom_range(9) < 7) load_table(rand_table());
      do_frame(pct, 1'($urandom_range(1)), ($urandom_range(3) == 0), rand_table());
      if (m_pending && $urandom_range(1) == 1) idle_cycles(1);
    end

    // Reset while a request is outstanding
    t = '0; t[6:0] = 7'd12; t[22:16] = 7'd13;
    load_table(t);
    @(posedge clk); #1;
    frame_tick = 1'b1;
    req_ready  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      #1;
      if (req_valid) seen = 1'b1;
    end
    check_eq("rst_pre_valid", seen, 1);
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_mid_outputs",
             {req_valid, req_slot, req_note, req_last, frame_done, busy, overrun, timeout_err}, 0);
    check_count("rst_mid_count");
    @(posedge clk); #1;
    check_eq("rst_hold_outputs",
             {req_valid, req_slot, req_note, req_last, frame_done, busy, overrun, timeout_err}, 0);
    rstn = 1'b1;
    idle_cycles(2);
    // Snapshot cleared by reset: behaves as an empty table
    do_frame(100, 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
